// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the ST7735 panel command path:
//   - ST7735 command bytes (CASET, RASET, RAMWR)
//   - index of the data/command bit inside a 9-bit SPI word
//   - default panel geometry
//   - state encoding of the rectangle-fill sequencer
//   - spi_word(): packs a D/C flag and a byte into a 9-bit SPI word
// ---------------------------------------------------------------------------
package lcd_pkg;

    localparam logic [7:0]  CASET = 8'h2A;
    localparam logic [7:0]  RASET = 8'h2B;
    localparam logic [7:0]  RAMWR = 8'h2C;

    // bit 8 of an SPI word: 1 = data byte, 0 = command byte
    localparam int unsigned DC_BIT = 32'd8;

    localparam int unsigned LCD_W_DEF = 32'd128;
    localparam int unsigned LCD_H_DEF = 32'd160;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_PIX_HI = 3'd2,
        ST_PIX_LO = 3'd3,
        ST_DONE   = 3'd4
    } fill_state_e;

    function automatic logic [8:0] spi_word(input logic dc, input logic [7:0] b);
        logic [8:0] w;
        w         = 9'd0;
        w[7:0]    = b;
        w[DC_BIT] = dc;
        return w;
    endfunction

endpackage

// File: rtl/lcd_fill_rect.sv
// ---------------------------------------------------------------------------
// lcd_fill_rect
// Rectangle-fill command generator for the ST7735 panel. On an accepted start
// it emits CASET/RASET window setup, RAMWR, then width*height RGB565 pixels
// (high byte, low byte), one 9-bit word per lcd_write handshake.
//
// Ports:
//   sys_clk    in   system clock
//   sys_rst    in   asynchronous active-high reset
//   start      in   one-cycle request, sampled only while idle
//   x0, y0     in   top-left corner of the rectangle
//   width      in   rectangle width in pixels
//   height     in   rectangle height in pixels
//   color      in   RGB565 fill colour
//   wr_done    in   one-cycle completion pulse from lcd_write
//   fill_data  out  SPI word: bit8=1 data, bit8=0 command, bits7:0 byte
//   en_write   out  one-cycle write strobe to lcd_write
//   busy       out  high from accepted start through the fill_done cycle
//   fill_done  out  one-cycle completion pulse
//
// Build option: LCD_FILL_CLIP_EN
//   defined   - rectangle is clipped to the panel
//   undefined - rectangles reaching past the panel edge are rejected and
//               complete like a zero-size fill (no SPI traffic)
// ---------------------------------------------------------------------------
module lcd_fill_rect
    import lcd_pkg::*;
#(
    parameter int unsigned LCD_W = LCD_W_DEF,
    parameter int unsigned LCD_H = LCD_H_DEF,
    parameter int unsigned X_OFS = 32'd0,
    parameter int unsigned Y_OFS = 32'd0
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic [8:0]  x0,
    input  logic [8:0]  y0,
    input  logic [8:0]  width,
    input  logic [8:0]  height,
    input  logic [15:0] color,
    input  logic        wr_done,
    output logic [8:0]  fill_data,
    output logic        en_write,
    output logic        busy,
    output logic        fill_done
);

    localparam logic [9:0] LCD_W_S = 10'(LCD_W);
    localparam logic [9:0] LCD_H_S = 10'(LCD_H);
    localparam logic [9:0] X_OFS_S = 10'(X_OFS);
    localparam logic [9:0] Y_OFS_S = 10'(Y_OFS);
    localparam logic [3:0] LAST_STEP = 4'd10;

    fill_state_e state_q, state_d;
    logic [3:0]  step_q, step_d;
    logic [16:0] pix_cnt_q, pix_cnt_d;
    logic [8:0]  xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [15:0] color_q, color_d;
    logic [8:0]  fill_data_q, fill_data_d;
    logic        en_write_q, en_write_d;
    logic        busy_q, busy_d;
    logic        fill_done_q, fill_done_d;

    logic [9:0]  x_end_s, y_end_s, x_lim_s, y_lim_s, w_eff_s, h_eff_s;
    logic [8:0]  xs_s, xe_s, ys_s, ye_s;
    logic [16:0] pix_total_s;
    logic        zero_s;
    logic [3:0]  rom_idx_s;
    logic [8:0]  rom_word_s;

    // Window geometry from the live inputs; only captured on an accepted start.
    // x_end/y_end are exclusive ends, 10 bits wide so x0+width cannot wrap.
    always_comb begin
        x_end_s = {1'b0, x0} + {1'b0, width};
        y_end_s = {1'b0, y0} + {1'b0, height};
`ifdef LCD_FILL_CLIP_EN
        x_lim_s = (x_end_s > LCD_W_S) ? LCD_W_S : x_end_s;
        y_lim_s = (y_end_s > LCD_H_S) ? LCD_H_S : y_end_s;
        w_eff_s = ({1'b0, x0} >= LCD_W_S) ? 10'd0 : (x_lim_s - {1'b0, x0});
        h_eff_s = ({1'b0, y0} >= LCD_H_S) ? 10'd0 : (y_lim_s - {1'b0, y0});
        zero_s  = (w_eff_s == 10'd0) || (h_eff_s == 10'd0);
`else
        x_lim_s = x_end_s;
        y_lim_s = y_end_s;
        w_eff_s = {1'b0, width};
        h_eff_s = {1'b0, height};
        zero_s  = (width == 9'd0) || (height == 9'd0) ||
                  (x_end_s > LCD_W_S) || (y_end_s > LCD_H_S);
`endif
        // only addr[8:0] ever reaches the panel
        xs_s        = 9'({1'b0, x0} + X_OFS_S);
        xe_s        = 9'(x_lim_s - 10'd1 + X_OFS_S);
        ys_s        = 9'({1'b0, y0} + Y_OFS_S);
        ye_s        = 9'(y_lim_s - 10'd1 + Y_OFS_S);
        pix_total_s = 17'(w_eff_s * h_eff_s);
    end

    // Setup step ROM, addressed by the step that is about to be sent.
    always_comb begin
        rom_idx_s = step_q + 4'd1;
        case (rom_idx_s)
            4'd0:    rom_word_s = spi_word(1'b0, CASET);
            4'd1:    rom_word_s = spi_word(1'b1, {7'd0, xs_q[8]});
            4'd2:    rom_word_s = spi_word(1'b1, xs_q[7:0]);
            4'd3:    rom_word_s = spi_word(1'b1, {7'd0, xe_q[8]});
            4'd4:    rom_word_s = spi_word(1'b1, xe_q[7:0]);
            4'd5:    rom_word_s = spi_word(1'b0, RASET);
            4'd6:    rom_word_s = spi_word(1'b1, {7'd0, ys_q[8]});
            4'd7:    rom_word_s = spi_word(1'b1, ys_q[7:0]);
            4'd8:    rom_word_s = spi_word(1'b1, {7'd0, ye_q[8]});
            4'd9:    rom_word_s = spi_word(1'b1, ye_q[7:0]);
            4'd10:   rom_word_s = spi_word(1'b0, RAMWR);
            default: rom_word_s = 9'd0;
        endcase
    end

    // Sequencer next state. Every word leaves with a one-cycle en_write and
    // fill_data then holds until wr_done; wr_done outside SETUP/PIX is ignored.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        pix_cnt_d   = pix_cnt_q;
        xs_d        = xs_q;
        xe_d        = xe_q;
        ys_d        = ys_q;
        ye_d        = ye_q;
        color_d     = color_q;
        fill_data_d = fill_data_q;
        en_write_d  = 1'b0;
        busy_d      = busy_q;
        fill_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    xs_d      = xs_s;
                    xe_d      = xe_s;
                    ys_d      = ys_s;
                    ye_d      = ye_s;
                    color_d   = color;
                    pix_cnt_d = pix_total_s;
                    step_d    = 4'd0;
                    busy_d    = 1'b1;
                    if (zero_s) begin
                        state_d     = ST_DONE;
                        fill_done_d = 1'b1;
                    end else begin
                        state_d     = ST_SETUP;
                        fill_data_d = spi_word(1'b0, CASET);
                        en_write_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (wr_done) begin
                    en_write_d = 1'b1;
                    if (step_q == LAST_STEP) begin
                        state_d     = ST_PIX_HI;
                        fill_data_d = spi_word(1'b1, color_q[15:8]);
                    end else begin
                        step_d      = step_q + 4'd1;
                        fill_data_d = rom_word_s;
                    end
                end else begin
                    state_d = ST_SETUP;
                end
            end
            ST_PIX_HI: begin
                if (wr_done) begin
                    state_d     = ST_PIX_LO;
                    fill_data_d = spi_word(1'b1, color_q[7:0]);
                    en_write_d  = 1'b1;
                end else begin
                    state_d = ST_PIX_HI;
                end
            end
            ST_PIX_LO: begin
                if (wr_done) begin
                    pix_cnt_d = pix_cnt_q - 17'd1;
                    if (pix_cnt_q == 17'd1) begin
                        state_d     = ST_DONE;
                        fill_done_d = 1'b1;
                    end else begin
                        state_d     = ST_PIX_HI;
                        fill_data_d = spi_word(1'b1, color_q[15:8]);
                        en_write_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_PIX_LO;
                end
            end
            ST_DONE: begin
                // busy and fill_done drop together here
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any fill without a completion pulse.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            step_q      <= 4'd0;
            pix_cnt_q   <= 17'd0;
            xs_q        <= 9'd0;
            xe_q        <= 9'd0;
            ys_q        <= 9'd0;
            ye_q        <= 9'd0;
            color_q     <= 16'd0;
            fill_data_q <= 9'd0;
            en_write_q  <= 1'b0;
            busy_q      <= 1'b0;
            fill_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            pix_cnt_q   <= pix_cnt_d;
            xs_q        <= xs_d;
            xe_q        <= xe_d;
            ys_q        <= ys_d;
            ye_q        <= ye_d;
            color_q     <= color_d;
            fill_data_q <= fill_data_d;
            en_write_q  <= en_write_d;
            busy_q      <= busy_d;
            fill_done_q <= fill_done_d;
        end
    end

    assign fill_data = fill_data_q;
    assign en_write  = en_write_q;
    assign busy      = busy_q;
    assign fill_done = fill_done_q;

endmodule

// File: tb/tb_lcd_fill_rect.sv
// ---------------------------------------------------------------------------
// tb_lcd_fill_rect
// Self-checking bench for lcd_fill_rect. A reference model builds the
// expected SPI word list of each rectangle from plain arithmetic; an
// lcd_write stand-in answers every en_write with wr_done after a random
// delay. Model follows LCD_FILL_CLIP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_lcd_fill_rect;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        start   = 1'b0;
    logic [8:0]  x0      = 9'd0;
    logic [8:0]  y0      = 9'd0;
    logic [8:0]  width   = 9'd0;
    logic [8:0]  height  = 9'd0;
    logic [15:0] color   = 16'd0;
    logic        wr_done = 1'b0;
    logic [8:0]  fill_data;
    logic        en_write;
    logic        busy;
    logic        fill_done;

    lcd_fill_rect dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .start    (start),
        .x0       (x0),
        .y0       (y0),
        .width    (width),
        .height   (height),
        .color    (color),
        .wr_done  (wr_done),
        .fill_data(fill_data),
        .en_write (en_write),
        .busy     (busy),
        .fill_done(fill_done)
    );

    always #5 sys_clk = ~sys_clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    logic [8:0] cap_q[$];
    logic [8:0] exp_q[$];
    int         first_en_cyc, fd_cnt, fd_cyc, last_wd_cyc, busy_cnt;
    int         max_delay = 0;
    bit         outst = 1'b0;
    int         cd = 0;
    logic [8:0] held = 9'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] w9(input int dc, input int b);
        return 9'((dc << 8) | (b & 255));
    endfunction

    // Expected word stream for one rectangle, straight from the panel rules.
    task automatic model(input int x, input int y, input int w, input int h, input logic [15:0] c);
        int wc, hc, xs, xe, ys, ye;
        exp_q.delete();
`ifdef LCD_FILL_CLIP_EN
        wc = (x >= 128) ? 0 : (((x + w > 128) ? 128 : x + w) - x);
        hc = (y >= 160) ? 0 : (((y + h > 160) ? 160 : y + h) - y);
`else
        if (x + w > 128 || y + h > 160) begin
            wc = 0;
            hc = 0;
        end else begin
            wc = w;
            hc = h;
        end
`endif
        if (wc == 0 || hc == 0) return;
        xs = x; xe = x + wc - 1; ys = y; ye = y + hc - 1;
        exp_q.push_back(w9(0, 'h2A));
        exp_q.push_back(w9(1, xs >> 8)); exp_q.push_back(w9(1, xs));
        exp_q.push_back(w9(1, xe >> 8)); exp_q.push_back(w9(1, xe));
        exp_q.push_back(w9(0, 'h2B));
        exp_q.push_back(w9(1, ys >> 8)); exp_q.push_back(w9(1, ys));
        exp_q.push_back(w9(1, ye >> 8)); exp_q.push_back(w9(1, ye));
        exp_q.push_back(w9(0, 'h2C));
        for (int p = 0; p < wc * hc; p++) begin
            exp_q.push_back({1'b1, c[15:8]});
            exp_q.push_back({1'b1, c[7:0]});
        end
    endtask

    // lcd_write stand-in and output monitor, sampling on the falling edge.
    always @(negedge sys_clk) begin
        wr_done = 1'b0;
        if (sys_rst) begin
            outst = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (fill_done) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
            if (en_write) begin
                check("no_write_while_outstanding", 32'(outst), 32'd0);
                cap_q.push_back(fill_data);
                if (first_en_cyc < 0) first_en_cyc = cyc;
                outst = 1'b1;
                held  = fill_data;
                cd    = int'($urandom_range(max_delay, 0));
            end else if (outst) begin
                check("data_stable", 32'(fill_data), 32'(held));
            end
            if (outst) begin
                if (cd == 0) begin
                    wr_done     = 1'b1;
                    outst       = 1'b0;
                    last_wd_cyc = cyc;
                end else begin
                    cd--;
                end
            end
        end
    end

    task automatic run_fill(input string tag, input int x, input int y, input int w, input int h,
                            input logic [15:0] c, input int dly, input bit restart);
        int budget, start_cyc, n;
        bit restarted;
        restarted = 1'b0;
        model(x, y, w, h, c);
        max_delay    = dly;
        cap_q.delete();
        first_en_cyc = -1;
        fd_cnt       = 0;
        fd_cyc       = -1;
        last_wd_cyc  = -1;
        busy_cnt     = 0;
        budget       = (exp_q.size() + 2) * (dly + 2) + 20;
        @(negedge sys_clk);
        x0 = 9'(x); y0 = 9'(y); width = 9'(w); height = 9'(h); color = c;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge sys_clk);
        start = 1'b0;
        // scramble inputs: the fill must keep using the latched values
        x0 = 9'($urandom); y0 = 9'($urandom); width = 9'($urandom); height = 9'($urandom);
        color = 16'($urandom);
        for (int i = 0; i < budget && fd_cnt == 0; i++) begin
            @(negedge sys_clk);
            start = 1'b0;
            if (restart && !restarted && cap_q.size() >= 5) begin
                start     = 1'b1;
                restarted = 1'b1;
            end
        end
        repeat (4) @(negedge sys_clk);
        start = 1'b0;
        check({tag, " fill_done_count"}, 32'(fd_cnt), 32'd1);
        check({tag, " word_count"}, 32'(cap_q.size()), 32'(exp_q.size()));
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s word%0d", tag, i), 32'(cap_q[i]), 32'(exp_q[i]));
        check({tag, " busy_len"}, 32'(busy_cnt), 32'(fd_cyc - start_cyc));
        if (exp_q.size() > 0) begin
            check({tag, " first_write_latency"}, 32'(first_en_cyc - start_cyc), 32'd1);
            check({tag, " done_latency"}, 32'(fd_cyc - last_wd_cyc), 32'd1);
        end else begin
            check({tag, " zero_done_latency"}, 32'(fd_cyc - start_cyc), 32'd1);
            check({tag, " zero_busy_cycles"}, 32'(busy_cnt), 32'd1);
        end
        check({tag, " idle_after"}, {29'd0, busy, en_write, fill_done}, 32'd0);
    endtask

    initial begin
        #1 sys_rst = 1'b1;
        #1;
        check("reset fill_data", 32'(fill_data), 32'd0);
        check("reset en_write", 32'(en_write), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset fill_done", 32'(fill_done), 32'd0);
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;

        run_fill("small", 10, 20, 2, 3, 16'h07E0, 2, 1'b0);
        run_fill("zero", 5, 5, 0, 5, 16'h1234, 0, 1'b0);
        run_fill("clip", 120, 0, 16, 3, 16'hABCD, 1, 1'b0);
        run_fill("stall", 30, 40, 3, 2, 16'($urandom), 20, 1'b1);
        run_fill("full", 0, 0, 128, 160, 16'hF800, 0, 1'b0);

        // abort a fill partway through the pixel phase
        max_delay = 3;
        cap_q.delete();
        fd_cnt = 0;
        first_en_cyc = -1;
        @(negedge sys_clk);
        x0 = 9'd4; y0 = 9'd4; width = 9'd8; height = 9'd8; color = 16'h5A5A;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        for (int i = 0; i < 2000 && cap_q.size() < 15; i++) @(negedge sys_clk);
        check("abort reached 15 words", 32'(cap_q.size() >= 15), 32'd1);
        #2 sys_rst = 1'b1;
        #1;
        check("abort fill_data", 32'(fill_data), 32'd0);
        check("abort en_write", 32'(en_write), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort fill_done", 32'(fill_done), 32'd0);
        repeat (3) @(negedge sys_clk);
        check("abort no fill_done", 32'(fd_cnt), 32'd0);
        sys_rst = 1'b0;
        run_fill("after_abort", 50, 60, 4, 3, 16'h0F0F, 3, 1'b0);

        for (int r = 0; r < 6; r++)
            run_fill($sformatf("rand%0d", r), int'($urandom_range(130, 0)), int'($urandom_range(162, 0)),
                     int'($urandom_range(9, 0)), int'($urandom_range(6, 0)),
                     16'($urandom), int'($urandom_range(5, 0)), 1'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
